// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures decoded control, operands and specifiers at the end of ID.
// Stall holds the stage, flush or an invalid ID loads a bubble, and a saturating counter tracks bubbles.
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_RegWrite,
    input  logic              id_MemtoReg,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_ALUSrc,
    input  logic              id_RegDst,
    input  logic [1:0]        id_ALUOp,
    input  logic [5:0]        id_funct,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    output logic              ex_valid,
    output logic              ex_RegWrite,
    output logic              ex_MemtoReg,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_ALUSrc,
    output logic              ex_RegDst,
    output logic [1:0]        ex_ALUOp,
    output logic [5:0]        ex_funct,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [CNT_W-1:0]  bubble_count
);

    logic              r_valid;
    logic [5:0]        r_ctrl;
    logic [1:0]        r_aluop;
    logic [5:0]        r_funct;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [CNT_W-1:0]  r_bubble_count;

    logic w_bubble;
    logic w_load;
    logic w_cnt_max;

    // Flush wins over stall; an idle ID stage on a normal advance is also a bubble.
    assign w_bubble  = flush | (~stall & ~id_valid);
    assign w_load    = ~flush & ~stall & id_valid;
    assign w_cnt_max = &r_bubble_count;

    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_aluop <= 2'b00;
            r_funct <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= {id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_ALUSrc, id_RegDst};
            r_aluop <= id_ALUOp;
            r_funct <= id_funct;
            r_rd1   <= id_rd1;
            r_rd2   <= id_rd2;
            r_imm   <= id_imm;
            r_rs    <= id_rs;
            r_rt    <= id_rt;
            r_rd    <= id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_count <= '0;
        end else if (w_bubble && !w_cnt_max) begin
            r_bubble_count <= r_bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ex_valid     = r_valid;
    assign ex_RegWrite  = r_ctrl[5];
    assign ex_MemtoReg  = r_ctrl[4];
    assign ex_MemRead   = r_ctrl[3];
    assign ex_MemWrite  = r_ctrl[2];
    assign ex_ALUSrc    = r_ctrl[1];
    assign ex_RegDst    = r_ctrl[0];
    assign ex_ALUOp     = r_aluop;
    assign ex_funct     = r_funct;
    assign ex_rd1       = r_rd1;
    assign ex_rd2       = r_rd2;
    assign ex_imm       = r_imm;
    assign ex_rs        = r_rs;
    assign ex_rt        = r_rt;
    assign ex_rd        = r_rd;
    assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register: directed pipeline scenarios followed by random traffic.
module tb_id_ex_register;

    typedef struct packed {
        logic        reset, stall, flush, valid;
        logic        regwrite, memtoreg, memread, memwrite, alusrc, regdst;
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic        regwrite, memtoreg, memread, memwrite, alusrc, regdst;
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
    } out_t;

    typedef struct packed {
        out_t  o;
        int    c16;
        int    c3;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t  cur;
    out_t act;
    logic [15:0] cnt16;
    logic [2:0]  cnt3;

    logic        s_valid, s_rw, s_m2r, s_mr, s_mw, s_as, s_rdst;
    logic [1:0]  s_aluop;
    logic [5:0]  s_funct;
    logic [31:0] s_rd1, s_rd2, s_imm;
    logic [4:0]  s_rs, s_rt, s_rd;

    id_ex_register dut (
        .clk(clk), .reset(cur.reset), .stall(cur.stall), .flush(cur.flush),
        .id_valid(cur.valid), .id_RegWrite(cur.regwrite), .id_MemtoReg(cur.memtoreg),
        .id_MemRead(cur.memread), .id_MemWrite(cur.memwrite), .id_ALUSrc(cur.alusrc),
        .id_RegDst(cur.regdst), .id_ALUOp(cur.aluop), .id_funct(cur.funct),
        .id_rd1(cur.rd1), .id_rd2(cur.rd2), .id_imm(cur.imm),
        .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
        .ex_valid(act.valid), .ex_RegWrite(act.regwrite), .ex_MemtoReg(act.memtoreg),
        .ex_MemRead(act.memread), .ex_MemWrite(act.memwrite), .ex_ALUSrc(act.alusrc),
        .ex_RegDst(act.regdst), .ex_ALUOp(act.aluop), .ex_funct(act.funct),
        .ex_rd1(act.rd1), .ex_rd2(act.rd2), .ex_imm(act.imm),
        .ex_rs(act.rs), .ex_rt(act.rt), .ex_rd(act.rd),
        .bubble_count(cnt16)
    );

    id_ex_register #(.CNT_W(3)) u_sat (
        .clk(clk), .reset(cur.reset), .stall(cur.stall), .flush(cur.flush),
        .id_valid(cur.valid), .id_RegWrite(cur.regwrite), .id_MemtoReg(cur.memtoreg),
        .id_MemRead(cur.memread), .id_MemWrite(cur.memwrite), .id_ALUSrc(cur.alusrc),
        .id_RegDst(cur.regdst), .id_ALUOp(cur.aluop), .id_funct(cur.funct),
        .id_rd1(cur.rd1), .id_rd2(cur.rd2), .id_imm(cur.imm),
        .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
        .ex_valid(s_valid), .ex_RegWrite(s_rw), .ex_MemtoReg(s_m2r),
        .ex_MemRead(s_mr), .ex_MemWrite(s_mw), .ex_ALUSrc(s_as),
        .ex_RegDst(s_rdst), .ex_ALUOp(s_aluop), .ex_funct(s_funct),
        .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
        .bubble_count(cnt3)
    );

    // Reference model: what EX should hold, in terms of the pipeline rules only.
    out_t m_out = '0;
    int   m_c16 = 0;
    int   m_c3  = 0;
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic in_t rand_in();
        in_t t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        t.reset = ($urandom_range(0, 39) == 0);
        t.stall = ($urandom_range(0, 3) == 0);
        t.flush = ($urandom_range(0, 7) == 0);
        t.valid = ($urandom_range(0, 4) != 0);
        return t;
    endfunction

    function automatic in_t idle_in();
        in_t t;
        t = rand_in();
        t.reset = 1'b0; t.stall = 1'b0; t.flush = 1'b0; t.valid = 1'b1;
        return t;
    endfunction

    task automatic drive(input in_t t);
        exp_t e;
        @(negedge clk);
        cur = t;
        if (t.reset) begin
            m_out = '0; m_c16 = 0; m_c3 = 0;
        end else if (t.flush || (!t.stall && !t.valid)) begin
            m_out = '0;
            m_c16 = (m_c16 < 65535) ? m_c16 + 1 : 65535;
            m_c3  = (m_c3 < 7) ? m_c3 + 1 : 7;
        end else if (!t.stall) begin
            m_out = {1'b1, t.regwrite, t.memtoreg, t.memread, t.memwrite, t.alusrc, t.regdst,
                     t.aluop, t.funct, t.rd1, t.rd2, t.imm, t.rs, t.rt, t.rd};
        end
        e.o = m_out; e.c16 = m_c16; e.c3 = m_c3;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if (act !== e.o) begin
                    n_fail++;
                    $display("FAIL ex_outputs t=%0t got=%h want=%h", $time, act, e.o);
                end
                n_tests++;
                if (cnt16 !== 16'(e.c16)) begin
                    n_fail++;
                    $display("FAIL bubble_count t=%0t got=%0d want=%0d", $time, cnt16, e.c16);
                end
                n_tests++;
                if (cnt3 !== 3'(e.c3)) begin
                    n_fail++;
                    $display("FAIL bubble_count_sat t=%0t got=%0d want=%0d", $time, cnt3, e.c3);
                end
            end
        end
    end

    initial begin : stim
        in_t t;
        int  wait_cyc;
        cur = '0;

        for (int i = 0; i < 2; i++) begin
            t = rand_in(); t.reset = 1'b1; drive(t);
        end

        t = '0; t.valid = 1; t.regwrite = 1; t.regdst = 1; t.aluop = 2'b10;
        t.funct = 6'b000010; t.rd1 = 32'd5; t.rd2 = 32'd7; t.rs = 5'd1; t.rt = 5'd2; t.rd = 5'd3;
        drive(t);

        t = '0; t.valid = 1; t.regwrite = 1; t.alusrc = 1; t.aluop = 2'b11; t.imm = 32'h0000_00FF;
        t.rs = 5'd4; t.rt = 5'd5;
        drive(t);

        t = '0; t.valid = 1; t.regwrite = 1; t.memread = 1; t.memtoreg = 1; t.alusrc = 1;
        t.imm = 32'd16; t.rt = 5'd8;
        drive(t);
        for (int i = 0; i < 3; i++) begin
            t = idle_in(); t.stall = 1'b1; drive(t);
        end
        drive(idle_in());

        t = '0; t.valid = 1; t.memwrite = 1; t.alusrc = 1; t.rd2 = 32'hDEAD_BEEF; t.imm = 32'd4;
        drive(t);
        t = idle_in(); t.flush = 1'b1; t.stall = 1'b1; drive(t);

        for (int i = 0; i < 4; i++) begin
            t = idle_in(); t.valid = 1'b0; t.regwrite = 1'b1; drive(t);
        end

        for (int i = 0; i < 10; i++) begin
            t = idle_in(); t.flush = 1'b1; drive(t);
        end
        t = idle_in(); t.stall = 1'b1; drive(t);
        t = idle_in(); t.reset = 1'b1; t.flush = 1'b1; drive(t);
        drive(idle_in());

        for (int i = 0; i < 600; i++) drive(rand_in());

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        #2;
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain got=%0d pending want=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
